// File: rtl/frame_writer_if.sv
// Byte-stream input and registered memory write port of frame_writer.
// slave is the frame_writer side; master is the stream source / memory side.
interface frame_writer_if #(
  parameter int ADDR_W = 17
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        wr_data;
  logic              frame_done;
  logic              err;
  logic [15:0]       checksum;

  modport master (
    output in_data, in_valid, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, frame_done, err, checksum
  );

  modport slave (
    input  in_data, in_valid, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, frame_done, err, checksum
  );
endinterface

// File: rtl/frame_writer.sv
// Frame memory write side: turns SOF/PIXEL bytes into sequential pixel writes.
// Optional running byte checksum enabled by defining FRAME_WRITER_CHECKSUM_EN.
module frame_writer #(
  parameter int H_PIXELS = 400,
  parameter int V_PIXELS = 300,
  parameter int ADDR_W   = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_writer_if.slave  bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECV   = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;
  localparam logic [1:0] CMD_PIXEL = 2'b00;
  localparam logic [1:0] CMD_SOF   = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;
  logic              err_r;
  logic              err_s;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [5:0]        wr_data_r;
  logic              frame_done_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              load_s;
  logic              done_s;
  logic [1:0]        cmd_s;

  // A new byte may enter whenever the output register is empty or draining.
  assign in_ready_s = !wr_en_r || bus.wr_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign cmd_s      = bus.in_data[7:6];

  // Next-state, address counter and error decode for the accepted byte.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    load_s  = 1'b0;
    done_s  = 1'b0;
    if (accept_s && (cmd_s == CMD_SOF)) begin
      state_s = ST_RECV;
      cnt_s   = {ADDR_W{1'b0}};
      err_s   = 1'b0;
    end else if (accept_s) begin
      case (state_r)
        ST_RECV: begin
          if (cmd_s == CMD_PIXEL) begin
            load_s = 1'b1;
            if (cnt_r == LAST_ADDR) begin
              state_s = ST_FULL;
              cnt_s   = {ADDR_W{1'b0}};
              done_s  = 1'b1;
            end else begin
              cnt_s = cnt_r + ADDR_W'(1);
            end
          end else begin
            err_s = 1'b1;
          end
        end
        ST_IDLE, ST_FULL: err_s = 1'b1;
        default: begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end
      endcase
    end else if ((state_r != ST_IDLE) && (state_r != ST_RECV) && (state_r != ST_FULL)) begin
      state_s = ST_IDLE;
    end else begin
      state_s = state_r;
    end
  end

  // Control state, counter and the one-entry write output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {ADDR_W{1'b0}};
      err_r        <= 1'b0;
      frame_done_r <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      wr_data_r    <= 6'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      err_r        <= err_s;
      frame_done_r <= done_s;
      if (load_s) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= cnt_r;
        wr_data_r <= bus.in_data[5:0];
      end else if (bus.wr_ready) begin
        wr_en_r <= 1'b0;
      end else begin
        wr_en_r <= wr_en_r;
      end
    end
  end

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0] checksum_r;
  logic        sof_s;

  assign sof_s = accept_s && (cmd_s == CMD_SOF);

  // Running modulo-2^16 sum of the pixel bytes written in the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= 16'd0;
    end else if (sof_s) begin
      checksum_r <= 16'd0;
    end else if (load_s) begin
      checksum_r <= checksum_r + {8'd0, bus.in_data};
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign bus.checksum = checksum_r;
`else
  assign bus.checksum = 16'd0;
`endif

  assign bus.in_ready   = in_ready_s;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.frame_done = frame_done_r;
  assign bus.err        = err_r;
endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer using a reduced 20x15 frame so a full frame
// and the last-pixel boundary are exercised quickly.
module tb_frame_writer;
  localparam int H      = 20;
  localparam int V      = 15;
  localparam int NPIX   = H * V;
  localparam int ADDR_W = 17;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

  frame_writer #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one byte and return 1 time unit after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %h, required 1", b);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    tests++; if (bus.wr_addr !== 17'd0) begin fails++; $display("FAIL reset_wr_addr: got %h expected 0", bus.wr_addr); end
    tests++; if (bus.wr_data !== 6'd0) begin fails++; $display("FAIL reset_wr_data: got %h expected 0", bus.wr_data); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    tests++; if (bus.checksum !== 16'd0) begin fails++; $display("FAIL reset_checksum: got %h expected 0", bus.checksum); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_pixel();
    send(8'h2A);
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL idle_pixel_wr_en: got %b expected 0", bus.wr_en); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL idle_pixel_err: got %b expected 1", bus.err); end
    send(8'h40);
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL idle_reserved_wr_en: got %b expected 0", bus.wr_en); end
    send(8'hC0);
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL idle_sof_err: got %b expected 0", bus.err); end
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL idle_sof_wr_en: got %b expected 0", bus.wr_en); end
  endtask

  task automatic test_full_frame();
    int bad_addr;
    int bad_data;
    int bad_ready;
    int done_cnt;
    int done_at;
    bad_addr = 0; bad_data = 0; bad_ready = 0; done_cnt = 0; done_at = -1;
    send(8'hC0);
    for (int i = 0; i < NPIX; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i % 64);
      #1;
      if (bus.in_ready !== 1'b1) bad_ready++;
      @(posedge clk); #1;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(i)) bad_addr++;
      if (bus.wr_data !== 6'(i % 64)) bad_data++;
      if (bus.frame_done === 1'b1) begin done_cnt++; done_at = i; end
    end
    bus.in_valid = 1'b0;
    tests++; if (bad_ready !== 0) begin fails++; $display("FAIL frame_in_ready: %0d stalled cycles, expected 0", bad_ready); end
    tests++; if (bad_addr !== 0) begin fails++; $display("FAIL frame_addr: %0d wrong addresses, expected 0", bad_addr); end
    tests++; if (bad_data !== 0) begin fails++; $display("FAIL frame_data: %0d wrong data words, expected 0", bad_data); end
    tests++; if (done_at !== NPIX - 1) begin fails++; $display("FAIL frame_done_pos: pulsed after pixel %0d, expected %0d", done_at, NPIX - 1); end
    @(posedge clk); #1;
    if (bus.frame_done === 1'b1) done_cnt++;
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL frame_done_count: got %0d pulses expected 1", done_cnt); end
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL frame_drain_wr_en: got %b expected 0", bus.wr_en); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL frame_err: got %b expected 0", bus.err); end
`ifdef FRAME_WRITER_CHECKSUM_EN
    tests++; if (bus.checksum !== 16'd9010) begin fails++; $display("FAIL frame_checksum: got %h expected %h", bus.checksum, 16'd9010); end
`else
    tests++; if (bus.checksum !== 16'd0) begin fails++; $display("FAIL frame_checksum: got %h expected 0", bus.checksum); end
`endif
  endtask

  task automatic test_overrun();
    send(8'h15);
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL overrun_wr_en: got %b expected 0", bus.wr_en); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL overrun_err: got %b expected 1", bus.err); end
    send(8'hC0);
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL overrun_sof_err: got %b expected 0", bus.err); end
    send(8'h15);
    tests++; if (bus.wr_en !== 1'b1) begin fails++; $display("FAIL restart_wr_en: got %b expected 1", bus.wr_en); end
    tests++; if (bus.wr_addr !== 17'd0) begin fails++; $display("FAIL restart_addr: got %h expected 0", bus.wr_addr); end
    tests++; if (bus.wr_data !== 6'h15) begin fails++; $display("FAIL restart_data: got %h expected 15", bus.wr_data); end
  endtask

  task automatic test_backpressure();
    int sent;
    int wrote;
    int cyc;
    int gap_bad;
    int stable_bad;
    int low_cnt;
    logic hold;
    logic [ADDR_W-1:0] prev_addr;
    logic [5:0] prev_data;
    sent = 0; wrote = 0; cyc = 0; gap_bad = 0; stable_bad = 0; low_cnt = 0;
    hold = 1'b0; prev_addr = '0; prev_data = '0;
    send(8'hC0);
    while ((sent < 12 || wrote < 12) && cyc < 100) begin
      bus.wr_ready = !(cyc >= 3 && cyc < 8);
      bus.in_valid = (sent < 12);
      bus.in_data  = 8'h10 + 8'(sent);
      #1;
      if (hold && (bus.wr_addr !== prev_addr || bus.wr_data !== prev_data)) stable_bad++;
      if (bus.in_valid && !bus.in_ready) low_cnt++;
      if (bus.wr_en && bus.wr_ready) begin
        if (bus.wr_addr !== ADDR_W'(wrote) || bus.wr_data !== 6'(8'h10 + 8'(wrote))) gap_bad++;
        wrote++;
      end
      hold      = bus.wr_en && !bus.wr_ready;
      prev_addr = bus.wr_addr;
      prev_data = bus.wr_data;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b1;
    tests++; if (wrote !== 12) begin fails++; $display("FAIL bp_writes: got %0d writes expected 12", wrote); end
    tests++; if (gap_bad !== 0) begin fails++; $display("FAIL bp_sequence: %0d out-of-order writes expected 0", gap_bad); end
    tests++; if (stable_bad !== 0) begin fails++; $display("FAIL bp_stable: %0d changes while stalled expected 0", stable_bad); end
    tests++; if (low_cnt !== 5) begin fails++; $display("FAIL bp_in_ready_low: got %0d cycles expected 5", low_cnt); end
  endtask

  task automatic test_sof_pending();
    int done_cnt;
    done_cnt = 0;
    send(8'hC0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h20 + 8'(i);
      @(posedge clk); #1;
      if (bus.frame_done === 1'b1) done_cnt++;
    end
    bus.wr_ready = 1'b0;
    bus.in_data  = 8'hC0;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL pend_in_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 17'd9) begin fails++; $display("FAIL pend_hold: wr_en %b addr %h expected 1/9", bus.wr_en, bus.wr_addr); end
    bus.wr_ready = 1'b1;
    #1;
    tests++; if (bus.wr_addr !== 17'd9 || bus.wr_data !== 6'h29) begin fails++; $display("FAIL pend_complete: addr %h data %h expected 9/29", bus.wr_addr, bus.wr_data); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (bus.frame_done === 1'b1) done_cnt++;
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL pend_sof_wr_en: got %b expected 0", bus.wr_en); end
    send(8'h07);
    if (bus.frame_done === 1'b1) done_cnt++;
    tests++; if (bus.wr_addr !== 17'd0 || bus.wr_data !== 6'h07) begin fails++; $display("FAIL pend_next: addr %h data %h expected 0/07", bus.wr_addr, bus.wr_data); end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL pend_frame_done: got %0d pulses expected 0", done_cnt); end
  endtask

  task automatic test_checksum();
    send(8'hC0);
    tests++; if (bus.checksum !== 16'd0) begin fails++; $display("FAIL cks_sof_clear: got %h expected 0", bus.checksum); end
    send(8'h01);
    send(8'h02);
    send(8'h3F);
`ifdef FRAME_WRITER_CHECKSUM_EN
    tests++; if (bus.checksum !== 16'h0042) begin fails++; $display("FAIL cks_sum: got %h expected 0042", bus.checksum); end
`else
    tests++; if (bus.checksum !== 16'h0000) begin fails++; $display("FAIL cks_sum: got %h expected 0000", bus.checksum); end
`endif
    send(8'h80);
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL recv_reserved_err: got %b expected 1", bus.err); end
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL recv_reserved_wr_en: got %b expected 0", bus.wr_en); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_idle_pixel();
    test_full_frame();
    test_overrun();
    test_backpressure();
    test_sof_pending();
    test_checksum();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_writer.md
# frame_writer

Loads a 400x300 frame of 2-bit-per-channel RGB pixels into the display frame memory from a byte stream, i.e. the write side of the pixel memory that the scan-out loader reads during the visible window. Accepts command/pixel bytes over a valid/ready handshake, generates sequential linear addresses 0..H_PIXELS*V_PIXELS-1, drives a registered write port with back-pressure, and flags frame completion and protocol errors.

## Interface
- H_PIXELS, 400, pixels per line
- V_PIXELS, 300, lines per frame
- ADDR_W, 17, write address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  8  byte: [7:6] command, [5:4] red, [3:2] green, [1:0] blue
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- wr_en  out  1  memory write request, held until wr_ready
- wr_ready  in  1  memory accepts write this cycle
- wr_addr  out  ADDR_W  linear pixel address
- wr_data  out  6  {red, green, blue}
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted
- err  out  1  sticky protocol error; cleared by reset or SOF
- checksum  out  16  running byte sum (see Configuration)

## Operation
- Commands: 2'b11 = SOF, 2'b00 = PIXEL, 2'b01/2'b10 = reserved (accepted, discarded, set err).
- States: IDLE (reset), RECV, FULL.
- IDLE: SOF -> RECV, address counter := 0, err := 0. PIXEL -> discarded, err := 1.
- RECV: PIXEL -> load wr_data = in_data[5:0], wr_addr = counter, wr_en := 1; counter += 1. When the accepted pixel has address H_PIXELS*V_PIXELS-1: -> FULL, frame_done pulses, counter := 0. SOF -> restart (counter := 0, err := 0), no frame_done.
- FULL: PIXEL -> discarded, err := 1 (overrun). SOF -> RECV as from IDLE.
- Counter never exceeds H_PIXELS*V_PIXELS-1; no wrap into a second frame without SOF.
- Discarded/reserved/SOF bytes never assert wr_en.
- Reset mid-operation: pending write abandoned (wr_en := 0), state IDLE.

## Timing
- Reset values: in_ready 1, wr_en 0, wr_addr 0, wr_data 0, frame_done 0, err 0, checksum 0, state IDLE.
- in_ready = !wr_en || wr_ready (combinational); one-entry output register, full throughput 1 pixel/cycle when wr_ready held high.
- Latency: pixel accepted in cycle N -> wr_en/wr_addr/wr_data valid from cycle N+1; held stable while wr_en && !wr_ready.
- Write completes in the cycle wr_en && wr_ready; wr_en deasserts next cycle unless a new pixel was accepted in that same cycle (back-to-back: wr_en stays 1, addr/data update).
- frame_done asserted in cycle N+1 (same cycle wr_en first presents the last pixel), exactly one cycle.
- SOF accepted while a write is pending: pending write still completes with its original address; next pixel uses address 0.
- err changes in the cycle after the offending byte is accepted.

## Configuration
- FRAME_WRITER_CHECKSUM_EN defined: checksum = 16-bit modulo-2^16 sum of in_data of every accepted PIXEL byte in RECV; cleared to 0 on SOF and reset; updates cycle after acceptance.
- Not defined: checksum tied to 16'd0, no adder logic.

## Test plan
- Reset, SOF, 120000 PIXEL bytes 0x00..0x3F cycling, wr_ready=1 -> addresses 0..119999 in order, one pixel/cycle, frame_done pulses once 1 cycle after last accept, state FULL, err=0.
- PIXEL 0x2A in IDLE -> no wr_en, err=1; then SOF -> err=0.
- After full frame, PIXEL 0x15 -> discarded, err=1; SOF + PIXEL 0x15 -> wr_addr=0, wr_data=6'h15.
- wr_ready low 5 cycles with continuous in_valid -> in_ready low, wr_addr/wr_data stable, no byte lost, address sequence gapless.
- SOF after 10 pixels with a write pending -> pending write to addr 9 completes, next pixel written to addr 0, no frame_done.
- With FRAME_WRITER_CHECKSUM_EN: SOF, pixels 0x01,0x02,0x3F -> checksum=16'h0042; without macro checksum stays 0.
